// File: rtl/sigmoid_inverse.sv
// sigmoid_inverse: two-stage pipelined decoder from an 8-bit probability code to a
// Q8.8 pre-activation, the exact inverse of the piecewise-linear sigmoid encoder.
module sigmoid_inverse #(
    parameter int INPUT_BITLENGTH   = 16,
    parameter int SIGMOID_BITLENGTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SIGMOID_BITLENGTH-1:0] in_s,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INPUT_BITLENGTH-1:0]   out_sum
);

    typedef enum logic [1:0] {
        SEG_LIN4  = 2'd0,   // t in 128..192, step 4
        SEG_LIN8  = 2'd1,   // t in 193..236, step 8
        SEG_LIN32 = 2'd2,   // t in 237..254, step 32
        SEG_SAT   = 2'd3    // t = 255
    } seg_e;

    logic        r_s1_valid;
    logic        r_s1_sign;
    logic [7:0]  r_s1_t;
    seg_e        r_s1_seg;
    logic        r_s2_valid;
    logic [15:0] r_s2_sum;

    logic        w_s1_load;
    logic        w_s2_load;
    logic        w_sign;
    logic [7:0]  w_t;
    seg_e        w_seg;
    logic [8:0]  w_diff;
    logic [15:0] w_abs;
    logic [15:0] w_sum;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    // Folding about 127.5: 255 - s is the bitwise complement of an 8-bit code.
    assign w_sign = ~in_s[7];
    assign w_t    = in_s[7] ? in_s : ~in_s;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_seg = SEG_SAT;
        if (w_t <= 8'd192)
            w_seg = SEG_LIN4;
        else if (w_t <= 8'd236)
            w_seg = SEG_LIN8;
        else if (w_t <= 8'd254)
            w_seg = SEG_LIN32;
    end

    always_comb begin
        w_diff = 9'd0;
        w_abs  = 16'd0;
        unique case (r_s1_seg)
            SEG_LIN4: begin
                w_diff = {1'b0, r_s1_t} - 9'd128;
                w_abs  = {7'd0, w_diff} << 2;
            end
            SEG_LIN8: begin
                w_diff = {1'b0, r_s1_t} - 9'd160;
                w_abs  = {7'd0, w_diff} << 3;
            end
            SEG_LIN32: begin
                w_diff = {1'b0, r_s1_t} - 9'd216;
                w_abs  = {7'd0, w_diff} << 5;
            end
            SEG_SAT: begin
                w_abs = 16'h0501;
            end
            default: begin
                w_abs = 16'h0000;
            end
        endcase
    end

    // s = 127 decodes to -1 LSB so the negative half never lands on +0.
    always_comb begin
        w_sum = w_abs;
        if (r_s1_sign)
            w_sum = (w_abs == 16'd0) ? 16'hFFFF : (~w_abs + 16'd1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_t     <= 8'd0;
            r_s1_seg   <= SEG_LIN4;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign <= w_sign;
                r_s1_t    <= w_t;
                r_s1_seg  <= w_seg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_sum   <= 16'd0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid)
                r_s2_sum <= w_sum;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_sum   = r_s2_sum;

endmodule

// File: tb/tb_sigmoid_inverse.sv
// Scoreboard bench for sigmoid_inverse: expected codes are queued on accept and
// checked (exact value and round trip through a forward sigmoid model) on emit.
`timescale 1ns/1ps
module tb_sigmoid_inverse;

    typedef struct {
        logic [7:0]  s;
        logic [15:0] exp_sum;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_s = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum;

    item_t       sb_q[$];
    item_t       cur_item;
    int          n_total = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          out_cnt, first_out_cyc, last_out_cyc;
    int          acc_cnt, first_acc_cyc;
    logic        stop_bp;

    sigmoid_inverse #(.INPUT_BITLENGTH(16), .SIGMOID_BITLENGTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s      (in_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Forward piecewise-linear sigmoid (the encoder this block inverts).
    function automatic logic [7:0] sigmoid_fwd(input logic [15:0] sum);
        logic        neg;
        logic [15:0] mag;
        logic [7:0]  t;
        neg = sum[15];
        mag = neg ? (~sum + 16'd1) : sum;
        if (mag <= 16'h0100)      t = 8'(128 + int'(mag >> 2));
        else if (mag <= 16'h029F) t = 8'(160 + int'(mag >> 3));
        else if (mag <= 16'h04DF) t = 8'(216 + int'(mag >> 5));
        else                      t = 8'd255;
        return neg ? 8'(255 - int'(t)) : t;
    endfunction

    function automatic logic [15:0] ref_inv(input logic [7:0] s);
        int t, a;
        t = (s >= 8'd128) ? int'(s) : 255 - int'(s);
        if (t <= 192)      a = (t - 128) * 4;
        else if (t <= 236) a = (t - 160) * 8;
        else if (t <= 254) a = (t - 216) * 32;
        else               a = 16'h0501;
        if (s >= 8'd128) return 16'(a);
        if (a == 0)      return 16'hFFFF;
        return 16'(-a);
    endfunction

    task automatic clear_stats();
        out_cnt = 0; acc_cnt = 0;
        first_out_cyc = 0; last_out_cyc = 0; first_acc_cyc = 0;
    endtask

    // Handshakes are stable mid-cycle; the transfer happens at the following rising edge.
    always @(negedge clk) begin
        item_t e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check($sformatf("value_s%0d", e.s), out_sum, e.exp_sum);
                    check($sformatf("roundtrip_s%0d", e.s), sigmoid_fwd(out_sum), e.s);
                end
                if (out_cnt == 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
                out_cnt++;
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(cur_item);
                if (acc_cnt == 0) first_acc_cyc = cyc;
                acc_cnt++;
            end
        end
    end

    // Entered and left at posedge+1.
    task automatic send(input logic [7:0] s, input logic [15:0] exp_sum);
        logic acc;
        int   waited;
        waited = 0;
        cur_item.s = s;
        cur_item.exp_sum = exp_sum;
        in_valid = 1'b1;
        in_s = s;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end while (!acc && waited < 1000);
        check("send_accepted", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 200 && (sb_q.size() != 0 || out_valid); i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0]  dir_s [10];
        logic [15:0] dir_e [10];
        dir_s = '{8'd128, 8'd192, 8'd236, 8'd255, 8'd127, 8'd0, 8'd64, 8'd193, 8'd237, 8'd254};
        dir_e = '{16'h0000, 16'h0100, 16'h0260, 16'h0501, 16'hFFFF,
                  16'hFAFF, 16'hFF04, 16'h0108, 16'h02A0, 16'h04C0};
        clear_stats();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed values, including segment boundaries
        for (int i = 0; i < 10; i++) send(dir_s[i], dir_e[i]);
        drain();

        // Full-code round trip, back to back
        clear_stats();
        out_ready = 1'b1;
        for (int s = 0; s < 256; s++) send(8'(s), ref_inv(8'(s)));
        drain();
        check("rt_latency", 32'(first_out_cyc - first_acc_cyc), 32'd2);
        check("rt_count", 32'(out_cnt), 32'd256);
        check("rt_contiguous", 32'(last_out_cyc - first_out_cyc), 32'd255);

        // Backpressure: only two items fit
        out_ready = 1'b0;
        send(8'd200, 16'h0140);
        send(8'd201, 16'h0148);
        in_valid = 1'b1;
        in_s = 8'd202;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_sum_hold", 32'(out_sum), 32'h0140);
        end
        @(posedge clk);
        #1;
        clear_stats();
        out_ready = 1'b1;
        send(8'd202, 16'h0150);
        drain();
        check("bp_count", 32'(out_cnt), 32'd3);
        check("bp_contiguous", 32'(last_out_cyc - first_out_cyc), 32'd2);

        // Random bubbles and backpressure
        clear_stats();
        stop_bp = 1'b0;
        fork
            begin
                for (int n = 0; n < 10000; n++) begin
                    while ($urandom_range(0, 2) == 0) begin
                        in_s = 8'($urandom_range(0, 255));
                        @(posedge clk);
                        #1;
                    end
                    send(8'(n * 37 + (n >> 8)), ref_inv(8'(n * 37 + (n >> 8))));
                    in_s = 8'($urandom_range(0, 255));
                end
                stop_bp = 1'b1;
            end
            begin
                while (!stop_bp) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();
        check("rand_count", 32'(out_cnt), 32'd10000);

        // Reset with two items in flight
        out_ready = 1'b0;
        send(8'd10, ref_inv(8'd10));
        send(8'd20, ref_inv(8'd20));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_sum", 32'(out_sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_stats();
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_no_stale", 32'(out_cnt), 32'd0);
        send(8'd128, 16'h0000);
        drain();
        check("post_rst_one_item", 32'(out_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
